// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings and FSM states.
package mdu_pkg;

   localparam logic [2:0] MDU_MULT  = 3'd0;
   localparam logic [2:0] MDU_MULTU = 3'd1;
   localparam logic [2:0] MDU_DIV   = 3'd2;
   localparam logic [2:0] MDU_DIVU  = 3'd3;
   localparam logic [2:0] MDU_MTHI  = 3'd4;
   localparam logic [2:0] MDU_MTLO  = 3'd5;

   typedef enum logic {
      S_IDLE,
      S_RUN
   } mdu_state_t;

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit multiply/divide result ({hi,lo}) for the MDU, plus a divide-by-zero indication.
module mdu_calc
   import mdu_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] result,
   output logic        div_zero
);

   logic [63:0] sprod;
   logic [63:0] uprod;
   logic [31:0] ma;
   logic [31:0] mb;
   logic [31:0] mq;
   logic [31:0] mr;
   logic [31:0] uq;
   logic [31:0] ur;

   // Signed division works on magnitudes, then re-applies signs; this also makes
   // 0x80000000 / -1 come out as lo=0x80000000, hi=0 without a special case.
   always_comb begin
      div_zero = (b == 32'd0);
      sprod    = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
      uprod    = {32'd0, a} * {32'd0, b};
      ma       = a[31] ? (32'd0 - a) : a;
      mb       = b[31] ? (32'd0 - b) : b;
      mq       = div_zero ? 32'd0 : (ma / mb);
      mr       = div_zero ? 32'd0 : (ma % mb);
      uq       = div_zero ? 32'd0 : (a / b);
      ur       = div_zero ? 32'd0 : (a % b);
      result   = 64'd0;
      case (op)
         MDU_MULT:  result = sprod;
         MDU_MULTU: result = uprod;
         MDU_DIV:   result = {(a[31] ? (32'd0 - mr) : mr),
                              ((a[31] ^ b[31]) ? (32'd0 - mq) : mq)};
         MDU_DIVU:  result = {ur, uq};
         default:   result = 64'd0;
      endcase
   end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding HI/LO; busy stalls the pipeline while an op runs.
// Optional divide-by-zero pulse output enabled by defining MDU_DIV0_FLAG_EN.
module mdu
   import mdu_pkg::*;
#(
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
)(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
`ifdef MDU_DIV0_FLAG_EN
   ,
   output logic        div0
`endif
);

   mdu_state_t  state;
   mdu_state_t  next_state;
   logic [15:0] cnt;
   logic [31:0] sh_hi;
   logic [31:0] sh_lo;
   logic        sh_div0;
   logic [63:0] calc_res;
   logic        calc_dz;
   logic        is_div;
   logic        accept;
   logic        done;

   mdu_calc u_calc (
      .op       (op),
      .a        (A),
      .b        (B),
      .result   (calc_res),
      .div_zero (calc_dz)
   );

   assign is_div = (op == MDU_DIV) || (op == MDU_DIVU);
   assign accept = (state == S_IDLE) && start && (op <= MDU_DIVU);
   assign done   = (state == S_RUN) && (cnt == 16'd0);
   assign busy   = (state == S_RUN);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (accept) next_state = S_RUN;
         S_RUN:   if (done)   next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // The shadow result is captured when the op is accepted, so operand changes
   // afterwards are irrelevant; a divide by zero leaves HI/LO untouched.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= 16'd0;
         sh_hi   <= 32'd0;
         sh_lo   <= 32'd0;
         sh_div0 <= 1'b0;
         hi      <= 32'd0;
         lo      <= 32'd0;
      end else begin
         if (accept) begin
            sh_hi   <= calc_res[63:32];
            sh_lo   <= calc_res[31:0];
            sh_div0 <= is_div && calc_dz;
            cnt     <= is_div ? 16'(DIV_LAT - 1) : 16'(MUL_LAT - 1);
         end else if ((state == S_RUN) && (cnt != 16'd0)) begin
            cnt <= cnt - 16'd1;
         end
         if (done && !sh_div0) begin
            hi <= sh_hi;
            lo <= sh_lo;
         end else if ((state == S_IDLE) && start && (op == MDU_MTHI)) begin
            hi <= A;
         end else if ((state == S_IDLE) && start && (op == MDU_MTLO)) begin
            lo <= A;
         end
      end
   end

`ifdef MDU_DIV0_FLAG_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) div0 <= 1'b0;
      else          div0 <= done && sh_div0;
   end
`endif

endmodule
